// File: rtl/vregfile_pkg.sv
// Shared definitions for vector_regfile: participation-select codes,
// clear-sequencer state type and the ppp -> byte-enable decoder.
package vregfile_pkg;

  localparam logic [2:0] PPP_ALL    = 3'b000;
  localparam logic [2:0] PPP_UPPER  = 3'b001;
  localparam logic [2:0] PPP_LOWER  = 3'b010;
  localparam logic [2:0] PPP_HIBYTE = 3'b011;
  localparam logic [2:0] PPP_LOBYTE = 3'b100;

  // Widest register supported by the decoder (512 bits).
  localparam int MAX_BYTES = 64;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_e;

  // Byte i is enabled according to the participation code; codes
  // 101..111 enable nothing so the write degenerates to a no-op.
  function automatic logic [MAX_BYTES-1:0] ppp_to_byte_en(input logic [2:0] ppp,
                                                          input int         nbytes);
    logic [MAX_BYTES-1:0] en;
    en = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < nbytes) begin
        case (ppp)
          PPP_ALL:    en[i] = 1'b1;
          PPP_UPPER:  en[i] = (i >= nbytes / 2);
          PPP_LOWER:  en[i] = (i < nbytes / 2);
          PPP_HIBYTE: en[i] = ((i % 2) == 1);
          PPP_LOBYTE: en[i] = ((i % 2) == 0);
          default:    en[i] = 1'b0;
        endcase
      end else begin
        en[i] = 1'b0;
      end
    end
    return en;
  endfunction

endpackage

// File: rtl/vregfile_lane_mask.sv
// Converts the participation select into a per-byte enable and the
// matching per-bit mask; one instance feeds both write and forward paths.
module vregfile_lane_mask
  import vregfile_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [2:0]          ppp_i,
  output logic [DATA_W/8-1:0] byte_en_o,
  output logic [DATA_W-1:0]   bit_mask_o
);

  localparam int NBYTES = DATA_W / 8;

  // Decode the select and widen each byte enable to eight mask bits.
  always_comb begin
    byte_en_o  = NBYTES'(ppp_to_byte_en(ppp_i, NBYTES));
    bit_mask_o = '0;
    for (int i = 0; i < NBYTES; i++) begin
      bit_mask_o[i*8 +: 8] = {8{byte_en_o[i]}};
    end
  end

endmodule

// File: rtl/vector_regfile.sv
// Participation-masked register file with NUM_RD combinational read
// ports and a multi-cycle soft-clear sequencer.
// Optional macro VREGFILE_BYPASS_EN adds per-byte write-to-read forwarding;
// without it a write becomes visible on rd_data the cycle after its edge.
module vector_regfile
  import vregfile_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [2:0]               ppp,
  output logic                     wr_ready,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0]   regfile_q [DEPTH];
  clr_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                sweep_we_s;
  logic                wr_commit_s;
  logic [DATA_W/8-1:0] byte_en_s;
  logic [DATA_W-1:0]   bit_mask_s;

  vregfile_lane_mask #(.DATA_W(DATA_W)) u_lane_mask (
    .ppp_i      (ppp),
    .byte_en_o  (byte_en_s),
    .bit_mask_o (bit_mask_s)
  );

  // A write lands only when accepted, non-zero address and at least one byte participates.
  assign wr_commit_s = wr_en & wr_ready & (wr_addr != '0) & (|byte_en_s);

  // Clear sequencer next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_ready   = 1'b0;
    clr_busy   = 1'b0;
    clr_done   = 1'b0;
    sweep_we_s = 1'b0;
    case (state_q)
      IDLE: begin
        wr_ready = 1'b1;
        if (clr_req) begin
          state_d = SWEEP;
          cnt_d   = ADDR_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      SWEEP: begin
        clr_busy   = 1'b1;
        sweep_we_s = 1'b1;
        if (cnt_q == LAST_IDX) begin
          clr_done = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state and sweep pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage: sweep zeroing has priority (writes are blocked then anyway); partial writes merge bytes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regfile_q[i] <= '0;
      end
    end else if (sweep_we_s) begin
      regfile_q[cnt_q] <= '0;
    end else if (wr_commit_s) begin
      regfile_q[wr_addr] <= (regfile_q[wr_addr] & ~bit_mask_s) | (wr_data & bit_mask_s);
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra_s;
    logic [DATA_W-1:0] stored_s;

    assign ra_s = rd_addr[k*ADDR_W +: ADDR_W];

    // Registered contents, with register 0 hardwired to zero.
    always_comb begin
      if (ra_s == '0) begin
        stored_s = '0;
      end else begin
        stored_s = regfile_q[ra_s];
      end
    end

`ifdef VREGFILE_BYPASS_EN
    // Forward participating bytes of a same-cycle committed write to this port.
    always_comb begin
      if (wr_commit_s && (ra_s == wr_addr)) begin
        rd_data[k*DATA_W +: DATA_W] = (stored_s & ~bit_mask_s) | (wr_data & bit_mask_s);
      end else begin
        rd_data[k*DATA_W +: DATA_W] = stored_s;
      end
    end
`else
    assign rd_data[k*DATA_W +: DATA_W] = stored_s;
`endif
  end

endmodule

// File: tb/tb_vector_regfile.sv
// Directed self-checking bench for vector_regfile: a default build
// (64x32, 2 read ports) and a 128-bit, 16-entry, 3-port build.
module tb_vector_regfile;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;

  // Default-parameter instance
  logic [9:0]   rd_addr_a = '0;
  logic [127:0] rd_data_a;
  logic         wr_en_a = 1'b0;
  logic [4:0]   wr_addr_a = '0;
  logic [63:0]  wr_data_a = '0;
  logic [2:0]   ppp_a = '0;
  logic         wr_ready_a, clr_req_a = 1'b0, clr_busy_a, clr_done_a;

  // Wide instance
  logic [11:0]  rd_addr_b = '0;
  logic [383:0] rd_data_b;
  logic         wr_en_b = 1'b0;
  logic [3:0]   wr_addr_b = '0;
  logic [127:0] wr_data_b = '0;
  logic [2:0]   ppp_b = '0;
  logic         wr_ready_b, clr_req_b = 1'b0, clr_busy_b, clr_done_b;

  vector_regfile u_dut_a (
    .clk(clk), .reset(reset), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .ppp(ppp_a),
    .wr_ready(wr_ready_a), .clr_req(clr_req_a), .clr_busy(clr_busy_a), .clr_done(clr_done_a)
  );

  vector_regfile #(.DATA_W(128), .ADDR_W(4), .NUM_RD(3)) u_dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .ppp(ppp_b),
    .wr_ready(wr_ready_b), .clr_req(clr_req_b), .clr_busy(clr_busy_b), .clr_done(clr_done_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr_a(input logic [4:0] a, input logic [63:0] d, input logic [2:0] p);
    @(negedge clk);
    wr_en_a = 1'b1; wr_addr_a = a; wr_data_a = d; ppp_a = p;
    @(negedge clk);
    wr_en_a = 1'b0;
  endtask

  task automatic rd_a(input logic [4:0] a0, input logic [4:0] a1,
                      output logic [63:0] d0, output logic [63:0] d1);
    rd_addr_a = {a1, a0};
    #1;
    d0 = rd_data_a[63:0];
    d1 = rd_data_a[127:64];
  endtask

  task automatic wr_b(input logic [3:0] a, input logic [127:0] d, input logic [2:0] p);
    @(negedge clk);
    wr_en_b = 1'b1; wr_addr_b = a; wr_data_b = d; ppp_b = p;
    @(negedge clk);
    wr_en_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d0, d1;
    logic [63:0] fwd_exp;
    int busy_cnt, done_cnt, done_at;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_wr_ready", wr_ready_a, 1);
    check_val("rst_clr_busy", clr_busy_a, 0);
    check_val("rst_clr_done", clr_done_a, 0);
    @(negedge clk);
    reset = 1'b1;

    // ---------------- partial writes ----------------
    wr_a(5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000);
    wr_a(5'd3, 64'h0123_4567_89AB_CDEF, 3'b011);
    rd_a(5'd3, 5'd3, d0, d1);
    check_val("hibyte_p0", d0, 64'h01FF_45FF_89FF_CDFF);
    check_val("hibyte_p1", d1, 64'h01FF_45FF_89FF_CDFF);

    wr_a(5'd5, 64'h1111_2222_3333_4444, 3'b010);
    rd_a(5'd5, 5'd0, d0, d1);
    check_val("lower_half", d0, 64'h0000_0000_3333_4444);
    wr_a(5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 3'b110);
    rd_a(5'd5, 5'd0, d0, d1);
    check_val("reserved_ppp", d0, 64'h0000_0000_3333_4444);

    wr_a(5'd9, 64'h0123_4567_89AB_CDEF, 3'b100);
    wr_a(5'd10, 64'h0123_4567_89AB_CDEF, 3'b001);
    rd_a(5'd9, 5'd10, d0, d1);
    check_val("lobyte", d0, 64'h0023_0067_00AB_00EF);
    check_val("upper_half", d1, 64'h0123_4567_0000_0000);

    wr_a(5'd0, 64'hDEAD_BEEF_DEAD_BEEF, 3'b000);
    rd_a(5'd0, 5'd0, d0, d1);
    check_val("r0_p0", d0, 64'h0);
    check_val("r0_p1", d1, 64'h0);

    // ---------------- forwarding ----------------
    wr_a(5'd7, 64'hAAAA_AAAA_AAAA_AAAA, 3'b000);
    @(negedge clk);
    wr_en_a = 1'b1; wr_addr_a = 5'd7; wr_data_a = 64'h5555_5555_0000_0000; ppp_a = 3'b001;
`ifdef VREGFILE_BYPASS_EN
    fwd_exp = 64'h5555_5555_AAAA_AAAA;
`else
    fwd_exp = 64'hAAAA_AAAA_AAAA_AAAA;
`endif
    rd_a(5'd7, 5'd3, d0, d1);
    check_val("fwd_same_cycle", d0, fwd_exp);
    check_val("fwd_other_port", d1, 64'h01FF_45FF_89FF_CDFF);
    @(negedge clk);
    wr_en_a = 1'b0;
    rd_a(5'd7, 5'd7, d0, d1);
    check_val("fwd_next_p0", d0, 64'h5555_5555_AAAA_AAAA);
    check_val("fwd_next_p1", d1, 64'h5555_5555_AAAA_AAAA);
    @(negedge clk);
    wr_en_a = 1'b1; wr_addr_a = 5'd0; wr_data_a = 64'hFFFF_FFFF_FFFF_FFFF; ppp_a = 3'b000;
    rd_a(5'd0, 5'd0, d0, d1);
    check_val("fwd_r0", d0, 64'h0);
    @(negedge clk);
    wr_en_a = 1'b0;

    // ---------------- soft clear ----------------
    for (int i = 1; i < 32; i++) begin
      wr_a(5'(i), 64'h1111_1111_0000_0000 + 64'(i), 3'b000);
    end
    @(negedge clk);
    clr_req_a = 1'b1; wr_en_a = 1'b1; wr_addr_a = 5'd4; wr_data_a = 64'hDEAD_0000_0000_BEEF; ppp_a = 3'b000;
    @(negedge clk);
    clr_req_a = 1'b0; wr_en_a = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int n = 1; n <= 40; n++) begin
      if (!clr_busy_a) break;
      busy_cnt++;
      if (clr_done_a) begin
        done_cnt++;
        done_at = busy_cnt;
      end
      if (n == 2) begin
        rd_a(5'd4, 5'd1, d0, d1);
        check_val("clr_same_cycle_write", d0, 64'hDEAD_0000_0000_BEEF);
        check_val("swept_r1", d1, 64'h0);
      end
      if (n == 5) begin
        check_val("sweep_wr_ready", wr_ready_a, 0);
        wr_en_a = 1'b1; wr_addr_a = 5'd2; wr_data_a = 64'h7777_7777_7777_7777; ppp_a = 3'b000;
        clr_req_a = 1'b1;
      end else begin
        wr_en_a = 1'b0;
        clr_req_a = 1'b0;
      end
      if (n == 20) begin
        rd_a(5'd31, 5'd3, d0, d1);
        check_val("unswept_r31", d0, 64'h1111_1111_0000_001F);
        check_val("swept_r3", d1, 64'h0);
      end
      @(negedge clk);
    end
    check_val("sweep_len", busy_cnt, 31);
    check_val("done_at", done_at, 31);
    check_val("done_pulses", done_cnt, 1);
    check_val("post_sweep_ready", wr_ready_a, 1);
    for (int i = 0; i < 32; i++) begin
      rd_a(5'(i), 5'(31 - i), d0, d1);
      check_val($sformatf("cleared_r%0d", i), {d1, d0}, 128'h0);
    end
    wr_a(5'd6, 64'h0F0F_0F0F_0F0F_0F0F, 3'b000);
    rd_a(5'd6, 5'd0, d0, d1);
    check_val("post_sweep_write", d0, 64'h0F0F_0F0F_0F0F_0F0F);

    // ---------------- reset mid-sweep ----------------
    wr_a(5'd31, 64'h1234_5678_9ABC_DEF0, 3'b000);
    wr_a(5'd12, 64'h0000_0000_0000_00C3, 3'b000);
    @(negedge clk);
    clr_req_a = 1'b1;
    @(negedge clk);
    clr_req_a = 1'b0;
    busy_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      if (!clr_busy_a) break;
      busy_cnt++;
      if (busy_cnt == 10) break;
      @(negedge clk);
    end
    check_val("reached_cycle10", busy_cnt, 10);
    reset = 1'b0;
    #1;
    check_val("mid_rst_busy", clr_busy_a, 0);
    check_val("mid_rst_ready", wr_ready_a, 1);
    rd_a(5'd31, 5'd12, d0, d1);
    check_val("mid_rst_r31", d0, 64'h0);
    check_val("mid_rst_r12", d1, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_val("after_rst_busy", clr_busy_a, 0);
    check_val("after_rst_ready", wr_ready_a, 1);

    // ---------------- wide build ----------------
    wr_b(4'd1, {128{1'b1}}, 3'b000);
    wr_b(4'd1, 128'h0, 3'b100);
    wr_b(4'd2, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 3'b100);
    rd_addr_b = {4'd0, 4'd2, 4'd1};
    #1;
    check_val("b_p0_r1", rd_data_b[127:0], {8{16'hFF00}});
    check_val("b_p1_r2", rd_data_b[255:128], 128'h0023_0067_00AB_00EF_00DC_0098_0054_0010);
    check_val("b_p2_r0", rd_data_b[383:256], 128'h0);
    rd_addr_b = {4'd1, 4'd0, 4'd2};
    #1;
    check_val("b_perm_p0", rd_data_b[127:0], 128'h0023_0067_00AB_00EF_00DC_0098_0054_0010);
    check_val("b_perm_p1", rd_data_b[255:128], 128'h0);
    check_val("b_perm_p2", rd_data_b[383:256], {8{16'hFF00}});
    @(negedge clk);
    clr_req_b = 1'b1;
    @(negedge clk);
    clr_req_b = 1'b0;
    busy_cnt = 0; done_at = 0;
    for (int n = 1; n <= 30; n++) begin
      if (!clr_busy_b) break;
      busy_cnt++;
      if (clr_done_b) done_at = busy_cnt;
      @(negedge clk);
    end
    check_val("b_sweep_len", busy_cnt, 15);
    check_val("b_done_at", done_at, 15);
    rd_addr_b = {4'd15, 4'd2, 4'd1};
    #1;
    check_val("b_cleared", rd_data_b[383:0] == 384'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
